uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 152 +++++++++++++++
 tb/tb_uart_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-entry hold buffer in front of the shifter.
module uart_tx #(
  parameter logic [23:0] baud_rate  = 24'd2000000,
  parameter logic [27:0] clock_freq = 28'd100000000
) (
  input  logic       uart_clock,
  input  logic       uart_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_d_out,
  output logic       uart_busy,
  output logic       tx_done
);

  localparam int unsigned timer_w    = 24;
  localparam int unsigned bit_period = int'(clock_freq) / int'(baud_rate);
  localparam logic [timer_w-1:0] timer_last = timer_w'(bit_period - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [timer_w-1:0] bit_timer, timer_next;
  logic [2:0]         bit_idx, idx_next;
  logic [7:0]         shifter, shift_next;
  logic [7:0]         hold_reg, hold_next;
  logic               hold_valid, hold_valid_next;
  logic               line_next, busy_next, done_next;
  logic               timer_end;
  logic               accept;

  // The buffer is free exactly when nothing is held; no transfer can coincide with an accept.
  assign tx_ready  = ~hold_valid;
  assign accept    = tx_valid & ~hold_valid;
  assign timer_end = (bit_timer == timer_last);

  // State register.
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) state <= IDLE;
    else             state <= state_next;
  end

  // Datapath and output registers; outputs are derived from next-state values so they align with state.
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      bit_timer  <= '0;
      bit_idx    <= '0;
      shifter    <= '0;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      uart_d_out <= 1'b1;
      uart_busy  <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      bit_timer  <= timer_next;
      bit_idx    <= idx_next;
      shifter    <= shift_next;
      hold_reg   <= hold_next;
      hold_valid <= hold_valid_next;
      uart_d_out <= line_next;
      uart_busy  <= busy_next;
      tx_done    <= done_next;
    end
  end

  // Next-state, bit timing, hold buffer handshake and line level.
  always_comb begin
    state_next      = state;
    timer_next      = bit_timer;
    idx_next        = bit_idx;
    shift_next      = shifter;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid;
    line_next       = 1'b1;
    busy_next       = 1'b0;
    done_next       = 1'b0;

    if (accept) begin
      hold_next       = tx_data;
      hold_valid_next = 1'b1;
    end

    case (state)
      IDLE: begin
        timer_next = '0;
        idx_next   = '0;
        if (hold_valid) begin
          shift_next      = hold_reg;
          hold_valid_next = 1'b0;
          state_next      = START;
        end
      end
      START: begin
        if (timer_end) begin
          timer_next = '0;
          idx_next   = '0;
          state_next = DATA;
        end else begin
          timer_next = bit_timer + timer_w'(1);
        end
      end
      DATA: begin
        if (timer_end) begin
          timer_next = '0;
          if (bit_idx == 3'd7) begin
            idx_next   = '0;
            state_next = STOP;
          end else begin
            idx_next = bit_idx + 3'd1;
          end
        end else begin
          timer_next = bit_timer + timer_w'(1);
        end
      end
      STOP: begin
        if (timer_end) begin
          timer_next = '0;
          // Back-to-back frames: a buffered byte goes straight into a new start bit.
          if (hold_valid) begin
            shift_next      = hold_reg;
            hold_valid_next = 1'b0;
            state_next      = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = bit_timer + timer_w'(1);
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
        idx_next   = '0;
      end
    endcase

    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = shift_next[idx_next];
      default: line_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE);
    done_next = (state_next == STOP) && (timer_next == timer_last);
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of framing, buffering, back-to-back frames and reset abort.
module tb_uart_tx;

  localparam int P     = 50;
  localparam int FRAME = 10 * P;

  logic       uart_clock;
  logic       uart_reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_d_out;
  logic       uart_busy;
  logic       tx_done;

  int n_vec;
  int n_err;
  int cyc;

  uart_tx dut (
    .uart_clock (uart_clock),
    .uart_reset (uart_reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_d_out (uart_d_out),
    .uart_busy  (uart_busy),
    .tx_done    (tx_done)
  );

  initial uart_clock = 1'b0;
  always #5 uart_clock = ~uart_clock;

  // Edge counter used to measure accept timing.
  always @(posedge uart_clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one byte and wait (bounded) for the accepting edge; returns the edge count before it.
  task automatic send(input logic [7:0] b, input bit drop_valid, output int acc_cyc);
    bit ok;
    logic r;
    ok = 1'b0;
    acc_cyc = 0;
    @(negedge uart_clock);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int k = 0; k < 2000 && !ok; k++) begin
      r = tx_ready;
      acc_cyc = cyc;
      @(posedge uart_clock);
      if (r) ok = 1'b1;
      else @(negedge uart_clock);
    end
    if (!ok) chk($sformatf("accept timeout %0h", b), 32'd0, 32'd1);
    @(negedge uart_clock);
    if (drop_valid) tx_valid = 1'b0;
  endtask

  // Observe one full frame starting at the next cycle; one comparison per bit slot plus done/busy.
  task automatic watch_frame(input logic [7:0] b);
    int   match [10];
    int   dones;
    int   busys;
    int   bi;
    logic exp;
    logic done_last;
    dones = 0;
    busys = 0;
    done_last = 1'b0;
    for (int i = 0; i < 10; i++) match[i] = 0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge uart_clock);
      bi = (c - 1) / P;
      if (bi == 0)      exp = 1'b0;
      else if (bi == 9) exp = 1'b1;
      else              exp = b[bi-1];
      if (uart_d_out === exp) match[bi]++;
      if (tx_done === 1'b1) dones++;
      if (uart_busy === 1'b1) busys++;
      if (c == FRAME) done_last = tx_done;
    end
    for (int i = 0; i < 10; i++)
      chk($sformatf("byte %0h slot %0d level cycles", b, i), 32'(match[i]), 32'(P));
    chk($sformatf("byte %0h done count", b), 32'(dones), 32'd1);
    chk($sformatf("byte %0h done at last cycle", b), 32'(done_last), 32'd1);
    chk($sformatf("byte %0h busy cycles", b), 32'(busys), 32'(FRAME));
  endtask

  int a1, a2, a3;
  int good;

  initial begin
    n_vec      = 0;
    n_err      = 0;
    cyc        = 0;
    uart_reset = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;

    // Reset values
    repeat (3) @(negedge uart_clock);
    chk("reset line", 32'(uart_d_out), 32'd1);
    chk("reset ready", 32'(tx_ready), 32'd1);
    chk("reset busy", 32'(uart_busy), 32'd0);
    chk("reset done", 32'(tx_done), 32'd0);
    uart_reset = 1'b1;
    repeat (10) @(negedge uart_clock);
    chk("idle after release line", 32'(uart_d_out), 32'd1);
    chk("idle after release busy", 32'(uart_busy), 32'd0);

    // 0x55: alternating line, start bit on the edge after accept
    send(8'h55, 1'b1, a1);
    chk("55 cycle0 line", 32'(uart_d_out), 32'd1);
    chk("55 cycle0 busy", 32'(uart_busy), 32'd0);
    watch_frame(8'h55);
    @(negedge uart_clock);
    chk("55 after frame busy", 32'(uart_busy), 32'd0);
    chk("55 after frame line", 32'(uart_d_out), 32'd1);
    repeat (5) @(negedge uart_clock);

    // 0xA5 then 0x3C: contiguous frames
    send(8'hA5, 1'b1, a1);
    fork
      begin
        watch_frame(8'hA5);
        watch_frame(8'h3C);
      end
      send(8'h3C, 1'b1, a2);
    join
    chk("3C accept offset", 32'(a2 - a1), 32'd2);
    @(negedge uart_clock);
    chk("A5/3C idle busy", 32'(uart_busy), 32'd0);
    repeat (5) @(negedge uart_clock);

    // Three bytes with tx_valid held high
    send(8'h01, 1'b0, a1);
    fork
      begin
        watch_frame(8'h01);
        watch_frame(8'h02);
        watch_frame(8'h03);
      end
      begin
        send(8'h02, 1'b0, a2);
        chk("ready low after 2nd accept", 32'(tx_ready), 32'd0);
        send(8'h03, 1'b1, a3);
      end
    join
    chk("02 accept offset", 32'(a2 - a1), 32'd2);
    chk("03 accept offset", 32'(a3 - a1), 32'd502);
    @(negedge uart_clock);
    chk("three bytes idle busy", 32'(uart_busy), 32'd0);
    repeat (5) @(negedge uart_clock);

    // Reset mid-frame of 0xFF with 0xAA buffered
    send(8'hFF, 1'b1, a1);
    send(8'hAA, 1'b1, a2);
    repeat (228) @(negedge uart_clock);
    chk("FF busy before abort", 32'(uart_busy), 32'd1);
    chk("FF ready with buffer", 32'(tx_ready), 32'd0);
    uart_reset = 1'b0;
    #1;
    chk("abort line", 32'(uart_d_out), 32'd1);
    chk("abort ready", 32'(tx_ready), 32'd1);
    chk("abort busy", 32'(uart_busy), 32'd0);
    good = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge uart_clock);
      if (tx_done === 1'b0) good++;
    end
    chk("abort no done in reset", 32'(good), 32'd3);
    uart_reset = 1'b1;
    good = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge uart_clock);
      if (uart_d_out === 1'b1 && uart_busy === 1'b0 && tx_done === 1'b0) good++;
    end
    chk("buffer discarded, stays idle", 32'(good), 32'd600);
    send(8'h0F, 1'b1, a1);
    watch_frame(8'h0F);
    repeat (5) @(negedge uart_clock);

    // 0x00: 450 low cycles then 50 high
    send(8'h00, 1'b1, a1);
    watch_frame(8'h00);
    repeat (5) @(negedge uart_clock);

    // tx_data toggling with tx_valid low does not disturb the frame
    send(8'h96, 1'b1, a1);
    fork
      watch_frame(8'h96);
      begin
        for (int i = 0; i < FRAME; i++) begin
          @(posedge uart_clock);
          #1 tx_data = 8'($urandom);
        end
      end
    join
    @(negedge uart_clock);
    chk("96 idle after toggles", 32'(uart_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
